// File: rtl/cnn_pkg.sv
// Shared CNN constants and the window tap extraction helper.
package cnn_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned WIN_TAPS  = 9;
    localparam int unsigned IMG_W_DEF = 32;
    localparam int unsigned IMG_H_DEF = 32;

    // Tap idx 0..8 in row-major order; tap 0 (top-left) sits in the top bits.
    function automatic logic [PIX_W-1:0] win_tap(
        input logic [WIN_TAPS*PIX_W-1:0] window,
        input int unsigned               idx
    );
        return window[(WIN_TAPS-1-idx)*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/conv_window_gen_3x3_if.sv
// Pixel-stream input and window-stream output of the 3x3 window generator.
interface conv_window_gen_3x3_if #(
    parameter int unsigned IMG_W = cnn_pkg::IMG_W_DEF,
    parameter int unsigned IMG_H = cnn_pkg::IMG_H_DEF,
    parameter int unsigned PIX_W = cnn_pkg::PIX_W
);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned WIN_W = cnn_pkg::WIN_TAPS * PIX_W;

    logic [PIX_W-1:0] in_pixel;
    logic             in_valid;
    logic             in_ready;
    logic [WIN_W-1:0] out_window;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             out_last;

    // Generator side
    modport slave (
        input  in_pixel, in_valid, out_ready,
        output in_ready, out_window, out_valid, out_row, out_col, out_last
    );

    // Source / sink side
    modport master (
        output in_pixel, in_valid, out_ready,
        input  in_ready, out_window, out_valid, out_row, out_col, out_last
    );
endinterface

// File: rtl/cnn_line_buffer.sv
// One image line of storage: single index, combinational read of the old word, write on the edge.
module cnn_line_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read returns the word as it was before this cycle's write.
    assign rd_data = mem_q[idx];

    // Contents need no reset: row/col gating hides stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= wr_data;
        end
    end
endmodule

// File: rtl/conv_window_gen_3x3.sv
// Raster pixel stream to packed 3x3 neighbourhoods for the sharpening convolution.
module conv_window_gen_3x3 #(
    parameter int unsigned IMG_W = cnn_pkg::IMG_W_DEF,
    parameter int unsigned IMG_H = cnn_pkg::IMG_H_DEF,
    parameter int unsigned PIX_W = cnn_pkg::PIX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    conv_window_gen_3x3_if.slave  bus
);
    import cnn_pkg::*;

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned WIN_W = WIN_TAPS * PIX_W;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [WIN_W-1:0] win_q, win_d, win_shift;
    logic             out_valid_q, out_valid_d;
    logic [WIN_W-1:0] out_window_q, out_window_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic             out_last_q, out_last_d;
    logic             in_ready_c;
    logic             accept;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    // Single-entry output register: accept whenever it is empty or draining.
    assign in_ready_c = !reset && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;

    // lb0 holds row-1, lb1 holds row-2; both shift down one line at the current column.
    cnn_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .idx     (col_q),
        .wr_en   (accept),
        .wr_data (bus.in_pixel),
        .rd_data (lb0_rd)
    );

    cnn_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .idx     (col_q),
        .wr_en   (accept),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Shift every window row left by one tap and append the new column {row-2, row-1, new pixel}.
    assign win_shift = {win_q[6*PIX_W +: 2*PIX_W], lb1_rd,
                        win_q[3*PIX_W +: 2*PIX_W], lb0_rd,
                        win_q[0       +: 2*PIX_W], bus.in_pixel};
    assign win_d     = accept ? win_shift : win_q;

    // Raster position tracking and output register update.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = out_valid_q;
        out_window_d = out_window_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_last_d   = out_last_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if ((row_q >= ROW_W'(2)) && (col_q >= COL_W'(2))) begin
                out_valid_d  = 1'b1;
                out_window_d = win_shift;
                out_row_d    = row_q - ROW_W'(1);
                out_col_d    = col_q - COL_W'(1);
                out_last_d   = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
            end
        end
    end

    // Control and output state, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
        end
    end

    // Shift window data is gated by row/col, so it is never reset.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_window = out_window_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_last   = out_last_q;
endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Self-checking bench for conv_window_gen_3x3: 4x4 frames with a frame-level model, plus a 32x32 frame.
module tb_conv_window_gen_3x3;
    import cnn_pkg::*;

    localparam int W4 = 4;
    localparam int H4 = 4;
    localparam int WB = 32;
    localparam int HB = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_window_gen_3x3_if #(.IMG_W(W4), .IMG_H(H4), .PIX_W(8)) if4 ();
    conv_window_gen_3x3_if #(.IMG_W(WB), .IMG_H(HB), .PIX_W(8)) if32 ();

    conv_window_gen_3x3 #(.IMG_W(W4), .IMG_H(H4), .PIX_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .bus(if4.slave));
    conv_window_gen_3x3 #(.IMG_W(WB), .IMG_H(HB), .PIX_W(8)) u_dut32 (
        .clk(clk), .reset(reset), .bus(if32.slave));

    typedef struct { logic [71:0] win; int row; int col; bit last; } win_t;
    typedef struct { int idx; logic [71:0] win; int row; int col; bit last; } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  in_q  [$];
    win_t        exp_q [$];
    win_t        cap_q [$];
    vec_t        tab   [6];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [71:0] pk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
        return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
    endfunction

    // Queue one 4x4 frame and every interior neighbourhood it should produce.
    task automatic add_frame(input int base, input bit rnd);
        logic [7:0]  img [H4][W4];
        win_t        w;
        for (int r = 0; r < H4; r++)
            for (int c = 0; c < W4; c++) begin
                img[r][c] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + 4*r + c);
                in_q.push_back(img[r][c]);
            end
        for (int r = 2; r < H4; r++)
            for (int c = 2; c < W4; c++) begin
                w.win = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w.win = {w.win[63:0], img[r-2+i][c-2+j]};
                w.row  = r - 1;
                w.col  = c - 1;
                w.last = (r == H4-1) && (c == W4-1);
                exp_q.push_back(w);
            end
    endtask

    // Drive in_q into the 4x4 DUT and check every transferred window against exp_q.
    // rdy_mode: 0 always ready, 1 stall 5 cycles on first window, 2 random.
    task automatic run4(input int rdy_mode, input bit bubbles, input bit chk_lat);
        int   cyc = 0, hold = 0, acc_n = 0, acc_cyc = -1, first_ov = -1;
        bit   trig = 0;
        win_t w;
        cap_q.delete();
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
            if4.in_valid = (in_q.size() > 0) && (!bubbles || $urandom_range(0, 1) == 1);
            if4.in_pixel = (in_q.size() > 0) ? in_q[0] : 8'($urandom_range(0, 255));
            if (rdy_mode == 1) begin
                if (!trig && if4.out_valid) begin
                    trig = 1;
                    hold = 5;
                end
                if4.out_ready = (hold == 0);
                if (hold > 0) hold--;
            end else if (rdy_mode == 2) begin
                if4.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                if4.out_ready = 1'b1;
            end
            @(negedge clk);
            if (rdy_mode == 1 && !if4.out_ready && exp_q.size() > 0) begin
                chk("stall_in_ready", 72'(if4.in_ready), 72'(0));
                chk("stall_valid", 72'(if4.out_valid), 72'(1));
                chk("stall_window", if4.out_window, exp_q[0].win);
            end
            if (if4.out_valid && first_ov < 0) first_ov = cyc;
            if (if4.out_valid && if4.out_ready) begin
                w.win = if4.out_window; w.row = int'(if4.out_row);
                w.col = int'(if4.out_col); w.last = if4.out_last;
                cap_q.push_back(w);
                if (exp_q.size() == 0) begin
                    chk("extra_window", 72'(1), 72'(0));
                end else begin
                    chk("win",  w.win, exp_q[0].win);
                    chk("row",  72'(w.row), 72'(exp_q[0].row));
                    chk("col",  72'(w.col), 72'(exp_q[0].col));
                    chk("last", 72'(w.last), 72'(exp_q[0].last));
                    void'(exp_q.pop_front());
                end
            end
            if (if4.in_valid && if4.in_ready) begin
                if (acc_n == 2*W4 + 2) acc_cyc = cyc;
                acc_n++;
                void'(in_q.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 2000) chk("run_timeout", 72'(1), 72'(0));
        if (chk_lat) chk("latency", 72'(first_ov - acc_cyc), 72'(1));
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        @(negedge clk);
        chk("drained", 72'(if4.out_valid), 72'(0));
        @(posedge clk); #1;
        in_q.delete();
        exp_q.delete();
    endtask

    // 32x32 gradient frame at the default geometry.
    task automatic run32();
        int n = 0, pix_i = 0, cyc = 0, er, ec;
        logic [71:0] ew;
        if32.out_ready = 1'b1;
        while (cyc < 1500) begin
            if32.in_valid = (pix_i < WB*HB);
            if32.in_pixel = 8'((pix_i / WB + pix_i % WB) & 255);
            @(negedge clk);
            if (if32.out_valid && if32.out_ready) begin
                n++;
                er = 1 + (n - 1) / (WB - 2);
                ec = 1 + (n - 1) % (WB - 2);
                ew = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew = {ew[63:0], 8'(er - 1 + i + ec - 1 + j)};
                chk("f32_row", 72'(if32.out_row), 72'(er));
                chk("f32_col", 72'(if32.out_col), 72'(ec));
                chk("f32_win", if32.out_window, ew);
                chk("f32_centre", 72'(win_tap(if32.out_window, 4)),
                    72'(8'(int'(if32.out_row) + int'(if32.out_col))));
                chk("f32_last", 72'(if32.out_last), 72'(n == (WB-2)*(HB-2)));
            end
            if (if32.in_valid && if32.in_ready) pix_i++;
            @(posedge clk); #1;
            cyc++;
            if (pix_i == WB*HB && !if32.out_valid) break;
        end
        if32.in_valid = 1'b0;
        chk("f32_pixels", 72'(pix_i), 72'(WB*HB));
        chk("f32_count", 72'(n), 72'(900));
    endtask

    initial begin
        tab[0] = '{0, pk(0, 1, 2, 4, 5, 6, 8, 9, 10),              1, 1, 0};
        tab[1] = '{1, pk(1, 2, 3, 5, 6, 7, 9, 10, 11),             1, 2, 0};
        tab[2] = '{2, pk(4, 5, 6, 8, 9, 10, 12, 13, 14),           2, 1, 0};
        tab[3] = '{3, pk(5, 6, 7, 9, 10, 11, 13, 14, 15),          2, 2, 1};
        tab[4] = '{4, pk(100, 101, 102, 104, 105, 106, 108, 109, 110), 1, 1, 0};
        tab[5] = '{7, pk(105, 106, 107, 109, 110, 111, 113, 114, 115), 2, 2, 1};

        reset = 1'b1;
        if4.in_valid  = 1'b0; if4.in_pixel  = '0; if4.out_ready  = 1'b1;
        if32.in_valid = 1'b0; if32.in_pixel = '0; if32.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 72'(if4.in_ready), 72'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid",  72'(if4.out_valid), 72'(0));
        chk("rst_window", if4.out_window, 72'(0));
        chk("rst_row",    72'(if4.out_row), 72'(0));
        chk("rst_col",    72'(if4.out_col), 72'(0));
        chk("rst_last",   72'(if4.out_last), 72'(0));
        chk("idle_ready", 72'(if4.in_ready), 72'(1));
        @(posedge clk); #1;

        // Ramp frame with latency check
        add_frame(0, 0);
        run4(0, 0, 1);
        chk("ramp_count", 72'(cap_q.size()), 72'(4));

        // Back-to-back frames against the hand-written table
        add_frame(0, 0);
        add_frame(100, 0);
        run4(0, 0, 0);
        chk("b2b_count", 72'(cap_q.size()), 72'(8));
        for (int k = 0; k < 6; k++) begin
            if (tab[k].idx < cap_q.size()) begin
                chk("tab_win",  cap_q[tab[k].idx].win, tab[k].win);
                chk("tab_row",  72'(cap_q[tab[k].idx].row), 72'(tab[k].row));
                chk("tab_col",  72'(cap_q[tab[k].idx].col), 72'(tab[k].col));
                chk("tab_last", 72'(cap_q[tab[k].idx].last), 72'(tab[k].last));
            end else begin
                chk("tab_missing", 72'(cap_q.size()), 72'(tab[k].idx + 1));
            end
        end

        // Backpressure on the first window
        add_frame(0, 0);
        run4(1, 0, 0);

        // Input bubbles
        add_frame(0, 0);
        run4(0, 1, 0);
        chk("bubble_count", 72'(cap_q.size()), 72'(4));

        // Reset with a window pending, then a clean ramp frame
        for (int k = 0; k < 11; k++) in_q.push_back(8'(200 + k));
        if4.out_ready = 1'b0;
        for (int cyc = 0; cyc < 50 && in_q.size() > 0; cyc++) begin
            if4.in_valid = 1'b1;
            if4.in_pixel = in_q[0];
            @(negedge clk);
            if (if4.in_valid && if4.in_ready) void'(in_q.pop_front());
            @(posedge clk); #1;
        end
        chk("mid_pending", 72'(if4.out_valid), 72'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 72'(if4.in_ready), 72'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_valid", 72'(if4.out_valid), 72'(0));
        chk("mid_row",   72'(if4.out_row), 72'(0));
        @(posedge clk); #1;
        in_q.delete();
        add_frame(0, 0);
        run4(0, 0, 1);
        chk("mid_count", 72'(cap_q.size()), 72'(4));

        // Random pixels, bubbles and backpressure over several frames
        for (int f = 0; f < 4; f++) add_frame(0, 1);
        run4(2, 1, 0);
        chk("rand_count", 72'(cap_q.size()), 72'(16));

        // Default geometry
        run32();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_window_gen_3x3.md
Name: conv_window_gen_3x3

Overview:
- Upstream feeder for the 3x3 sharpening convolution stage.
- Accepts a raster-order pixel stream (row-major, one pixel per handshake) and holds two line buffers plus a 3x3 shift window.
- Emits one packed 3x3 neighbourhood per valid interior output position (no padding), using the same row-major, top-left-first byte order as the convolution filter vector.
- The window packing lines up one-for-one with the 9 filter taps.

Parameters:
- IMG_W, 32, image width in pixels (≥3)
- IMG_H, 32, image height in pixels (≥3)
- PIX_W, 8, pixel width in bits (unsigned)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_pixel  in  PIX_W  incoming pixel
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- out_window  out  9*PIX_W  packed window: [9*PIX_W-1 -: PIX_W] = p(r-2,c-2) … [PIX_W-1:0] = p(r,c), row-major
- out_valid  out  1  out_window valid
- out_ready  in  1  downstream accepts window
- out_row  out  clog2(IMG_H)  window-centre row (r-1)
- out_col  out  clog2(IMG_W)  window-centre column (c-1)
- out_last  out  1  final window of the frame (qualified by out_valid)

Behaviour:
- **Reset** (synchronous, active-high, dominates all other inputs):
  - col=0, row=0.
  - out_valid=0, out_last=0, out_window=0, out_row=0, out_col=0.
  - Line-buffer and shift-window contents are not cleared; they are don't-care because of row/col gating.
- **Accept rule:**
  - in_ready = !out_valid || out_ready (single-entry output register, full throughput).
  - A pixel is accepted when in_valid && in_ready.
  - in_ready is 0 during the reset cycle.
- **On accept of pixel p at position (row, col):**
  - Shift window columns left by one. New right column = {lb1[col], lb0[col], p}, where lb1 is the older line (row-2) and lb0 is row-1.
  - Write lb1[col] <= lb0[col], then lb0[col] <= p. Reads and writes use the same index in the same cycle; old data is read first.
  - col increments. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts with no idle cycle.
- **Emit:**
  - If row≥2 and col≥2 at accept, then on the next edge: out_valid=1, out_window=new window, out_row=row-1, out_col=col-1.
  - out_last=1 iff (row,col)=(IMG_H-1,IMG_W-1).
- **Latency:** 1 cycle from accepting the window's bottom-right pixel to out_valid.
- **Output handshake:**
  - If out_valid && out_ready and no new window is produced this cycle, out_valid -> 0 on the next edge.
  - Accept and emit in the same cycle replaces the register contents.
  - While out_valid && !out_ready, out_window/out_row/out_col/out_last are held stable and in_ready=0.
- **Window counts and gaps:**
  - Windows per frame = (IMG_W-2)*(IMG_H-2); 900 at the defaults.
  - Pixels at col<2 or row<2 update state but produce no output, which leaves valid gaps at row starts.
- **Arithmetic:** pixels are passed through unmodified, treated as unsigned; there is no sign extension. Widening to 16 bits is done downstream.
- **in_valid with in_ready=0:** no state change; upstream must hold in_pixel.
- **Reset mid-frame:** any pending window is dropped and the next accepted pixel is (0,0).

Decomposition:
- **Shared package cnn_pkg:**
  - Constants PIX_W, WIN_TAPS=9, IMG_W/IMG_H defaults.
  - Function win_tap(window, idx) extracting tap idx 0..8 in row-major order, used by both this block and the convolution stage.
- **One sub-module, cnn_line_buffer:**
  - Depth IMG_W, width PIX_W, single index, read-before-write.
  - Instantiated twice (lb0, lb1).

Test Plan:
1. **Ramp window.** IMG_W=IMG_H=4, pixels v=4r+c streamed with in_valid=1, out_ready=1 -> first out_valid 1 cycle after accepting pixel 10, out_window bytes {0,1,2,4,5,6,8,9,10}, out_row=1, out_col=1; exactly 4 windows total, the last {5,6,7,9,10,11,13,14,15} with out_last=1.
2. **Default frame count.** 32x32 frame, pixel = (r+c)&0xFF -> exactly 900 windows; each window's centre byte equals out_row+out_col; out_last only on window 900 (out_row=30, out_col=30).
3. **Backpressure.** Ramp 4x4, out_ready=0 for 5 cycles once the first window is valid -> in_ready=0, out_window held at {0,1,2,4,5,6,8,9,10}, no pixel consumed; after release, remaining windows are identical to scenario 1.
4. **Input bubbles.** in_valid toggled pseudo-randomly on the 4x4 ramp -> same 4 windows, same order, no duplicates.
5. **Back-to-back frames.** Two 4x4 frames, second frame v=4r+c+100, no idle cycle between -> 8 windows; window 5 = {100,101,102,104,105,106,108,109,110}; no window mixes the two frames.
6. **Reset mid-frame.** Assert reset for 1 cycle after 9 pixels of a 4x4 frame, then send a full ramp frame -> out_valid=0 immediately after reset; output matches scenario 1 exactly.
